// File: rtl/muldiv_sequencer.sv
// Iterative shift-add multiply / restoring divide with HI/LO registers and pipeline stall.
// Optional signed support is built when SIGNED_MULDIV_EN is defined.
module muldiv_sequencer #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [1:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_hilo_read,
   output logic             o_ready,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_div_by_zero,
   output logic             o_stall,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   // state     | meaning
   // S_IDLE    | waiting for start
   // S_MUL_RUN | one shift-add multiply step per cycle
   // S_DIV_RUN | one restoring-divide quotient bit per cycle
   // S_FIX     | sign correction of the magnitude result (signed build only)
   // S_DONE    | result visible in hi/lo, done pulse, can accept again
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_MUL_RUN = 3'd1,
      S_DIV_RUN = 3'd2,
`ifdef SIGNED_MULDIV_EN
      S_FIX     = 3'd4,
`endif
      S_DONE    = 3'd3
   } state_t;

   state_t             r_state, w_next;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_wa, r_wh, r_wl;
   logic [WIDTH-1:0]   r_hi, r_lo;
   logic               r_div_by_zero;

   logic               w_accept, w_b_zero, w_last, w_sa, w_sb, w_signed;
   logic [WIDTH-1:0]   w_a_mag, w_b_mag;
   logic [WIDTH:0]     w_mul_sum, w_div_sh, w_div_diff;
   logic               w_div_ok;
   logic [WIDTH-1:0]   w_step_hi, w_step_lo;

`ifdef SIGNED_MULDIV_EN
   logic               r_signed, r_is_div, r_neg_q, r_neg_r;
   logic [2*WIDTH-1:0] w_prod_neg;
   assign w_signed   = i_op[1];
   assign w_sa       = i_op[1] & i_a[WIDTH-1];
   assign w_sb       = i_op[1] & i_b[WIDTH-1];
   assign w_prod_neg = -{r_wh, r_wl};
`else
   logic               w_unused_op1;
   assign w_unused_op1 = i_op[1];
   assign w_signed     = 1'b0;
   assign w_sa         = 1'b0;
   assign w_sb         = 1'b0;
`endif

   assign o_ready       = (r_state == S_IDLE) || (r_state == S_DONE);
   assign o_busy        = ~o_ready;
   assign o_done        = (r_state == S_DONE);
   assign o_stall       = i_hilo_read & o_busy;
   assign o_hi          = r_hi;
   assign o_lo          = r_lo;
   assign o_div_by_zero = r_div_by_zero;

   assign w_accept = i_start & o_ready;
   assign w_b_zero = (i_b == '0);
   assign w_last   = (r_cnt == '0);
   assign w_a_mag  = w_sa ? -i_a : i_a;
   assign w_b_mag  = w_sb ? -i_b : i_b;

   // Multiply: r_wl starts as the multiplier; product bits shift in from the top.
   assign w_mul_sum = {1'b0, r_wh} + (r_wl[0] ? {1'b0, r_wa} : '0);
   // Remainder < divisor before the shift, so the trial difference fits WIDTH+1 bits signed.
   assign w_div_sh   = {r_wh, r_wl[WIDTH-1]};
   assign w_div_diff = w_div_sh - {1'b0, r_wa};
   assign w_div_ok   = ~w_div_diff[WIDTH];

   always_comb begin
      w_step_hi = w_mul_sum[WIDTH:1];
      w_step_lo = {w_mul_sum[0], r_wl[WIDTH-1:1]};
      if (r_state == S_DIV_RUN) begin
         w_step_hi = w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
         w_step_lo = {r_wl[WIDTH-2:0], w_div_ok};
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_accept) begin
               if (i_op[0] && w_b_zero) w_next = S_DONE;
               else if (i_op[0])        w_next = S_DIV_RUN;
               else                     w_next = S_MUL_RUN;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_MUL_RUN, S_DIV_RUN: begin
            if (w_last) begin
`ifdef SIGNED_MULDIV_EN
               w_next = r_signed ? S_FIX : S_DONE;
`else
               w_next = S_DONE;
`endif
            end
         end
`ifdef SIGNED_MULDIV_EN
         S_FIX:   w_next = S_DONE;
`endif
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_cnt         <= '0;
         r_wa          <= '0;
         r_wh          <= '0;
         r_wl          <= '0;
         r_hi          <= '0;
         r_lo          <= '0;
         r_div_by_zero <= 1'b0;
`ifdef SIGNED_MULDIV_EN
         r_signed      <= 1'b0;
         r_is_div      <= 1'b0;
         r_neg_q       <= 1'b0;
         r_neg_r       <= 1'b0;
`endif
      end else if (w_accept) begin
         r_div_by_zero <= i_op[0] & w_b_zero;
         r_cnt         <= CNT_W'(WIDTH - 1);
         r_wh          <= '0;
         r_wa          <= i_op[0] ? w_b_mag : w_a_mag;
         r_wl          <= i_op[0] ? w_a_mag : w_b_mag;
`ifdef SIGNED_MULDIV_EN
         r_signed      <= w_signed;
         r_is_div      <= i_op[0];
         r_neg_q       <= w_sa ^ w_sb;
         r_neg_r       <= w_sa;
`endif
         if (i_op[0] && w_b_zero) begin
            r_hi <= i_a;
            r_lo <= '1;
         end
      end else if (r_state == S_MUL_RUN || r_state == S_DIV_RUN) begin
         r_cnt <= r_cnt - 1'b1;
         r_wh  <= w_step_hi;
         r_wl  <= w_step_lo;
         if (w_last && !w_signed_run()) begin
            r_hi <= w_step_hi;
            r_lo <= w_step_lo;
         end
`ifdef SIGNED_MULDIV_EN
      end else if (r_state == S_FIX) begin
         if (r_is_div) begin
            r_lo <= r_neg_q ? -r_wl : r_wl;
            r_hi <= r_neg_r ? -r_wh : r_wh;
         end else begin
            {r_hi, r_lo} <= r_neg_q ? w_prod_neg : {r_wh, r_wl};
         end
`endif
      end
   end

   function automatic logic w_signed_run();
`ifdef SIGNED_MULDIV_EN
      return r_signed;
`else
      return 1'b0;
`endif
   endfunction

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer; signed vectors run when SIGNED_MULDIV_EN is defined.
module tb_muldiv_sequencer;
   localparam int W = 32;

   logic         clk_sys = 1'b0;
   logic         reset, start, hilo_read;
   logic [1:0]   op;
   logic [W-1:0] a, b, hi, lo;
   logic         ready, busy, done, dbz, stall;
   int           n_vec = 0;
   int           n_err = 0;

   always #5 clk_sys = ~clk_sys;

   muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
      .i_clock(clk_sys), .i_reset(reset), .i_start(start), .i_op(op),
      .i_a(a), .i_b(b), .i_hilo_read(hilo_read),
      .o_ready(ready), .o_busy(busy), .o_done(done), .o_div_by_zero(dbz),
      .o_stall(stall), .o_hi(hi), .o_lo(lo)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   // Drives start over one edge; returns sampled in cycle 1 after accept.
   task automatic do_start(input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb);
      op = o; a = va; b = vb; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int cyc0, input int exp_cyc, input string tag);
      int cyc = cyc0;
      while (!done && cyc < 200) begin
         tick();
         cyc++;
      end
      check(tag, 64'(cyc), 64'(exp_cyc));
   endtask

   initial begin
      int saw_done;
      reset = 1'b1; start = 1'b0; hilo_read = 1'b0; op = 2'b00; a = '0; b = '0;
      tick(); tick();
      reset = 1'b0;
      check("rst_ready", 64'(ready), 64'd1);
      check("rst_flags", {59'd0, busy, done, dbz, stall, 1'b0}, 64'd0);
      check("rst_hilo", {hi, lo}, 64'd0);

      // 7 * 6
      do_start(2'b00, 32'd7, 32'd6);
      check("mul_busy", 64'(busy), 64'd1);
      wait_done(1, 33, "mul_lat");
      check("mul_hilo", {hi, lo}, {32'd0, 32'd42});
      check("mul_dbz", 64'(dbz), 64'd0);
      tick();

      // full-width multiply, start pulse and MFHI during busy
      do_start(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      tick(); tick(); tick();
      op = 2'b01; a = 32'd1; b = 32'd0; start = 1'b1; hilo_read = 1'b1;
      #1;
      check("stall_busy", 64'(stall), 64'd1);
      check("hold_hilo", {hi, lo}, {32'd0, 32'd42});
      tick();
      start = 1'b0; hilo_read = 1'b0;
      check("ign_dbz", 64'(dbz), 64'd0);
      check("ign_busy", 64'(busy), 64'd1);
      wait_done(5, 33, "mulff_lat");
      check("mulff_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

      // 100 / 7, then back-to-back 3 * 5 from DONE
      tick();
      do_start(2'b01, 32'd100, 32'd7);
      wait_done(1, 33, "div_lat");
      check("div_hilo", {hi, lo}, {32'd2, 32'd14});
      hilo_read = 1'b1;
      #1;
      check("stall_done", 64'(stall), 64'd0);
      hilo_read = 1'b0;
      do_start(2'b00, 32'd3, 32'd5);
      check("b2b_busy", 64'(busy), 64'd1);
      wait_done(34, 66, "b2b_lat");
      check("b2b_hilo", {hi, lo}, {32'd0, 32'd15});
      tick();

      // divide by zero
      do_start(2'b01, 32'd5, 32'd0);
      check("dz_done", 64'(done), 64'd1);
      check("dz_hilo", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
      check("dz_flag", 64'(dbz), 64'd1);
      tick();
      check("dz_sticky", {62'd0, dbz, done}, 64'b10);
      do_start(2'b01, 32'd9, 32'd4);
      check("dz_clear", 64'(dbz), 64'd0);
      wait_done(1, 33, "div2_lat");
      check("div2_hilo", {hi, lo}, {32'd1, 32'd2});
      tick();

      // reset at cycle 10 of a multiply
      do_start(2'b00, 32'd7, 32'd6);
      repeat (9) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_state", {61'd0, ready, busy, done}, 64'b100);
      check("abort_hilo", {hi, lo}, 64'd0);
      saw_done = 0;
      repeat (40) begin
         tick();
         if (done) saw_done = 1;
      end
      check("abort_nodone", 64'(saw_done), 64'd0);

      // reset and start together
      reset = 1'b1;
      do_start(2'b00, 32'd2, 32'd2);
      reset = 1'b0;
      check("rst_start", 64'(busy), 64'd0);
      tick();

`ifdef SIGNED_MULDIV_EN
      do_start(2'b10, 32'hFFFF_FFF9, 32'd6);
      wait_done(1, 34, "smul_lat");
      check("smul_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFD6);
      tick();
      do_start(2'b11, 32'hFFFF_FFF9, 32'd2);
      wait_done(1, 34, "sdiv_lat");
      check("sdiv_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      tick();
      do_start(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(1, 34, "sovf_lat");
      check("sovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);
      tick();
`else
      // op[1] ignored: operands treated as unsigned
      do_start(2'b10, 32'hFFFF_FFF9, 32'd6);
      wait_done(1, 33, "umul_lat");
      check("umul_hilo", {hi, lo}, 64'h0000_0005_FFFF_FFD6);
      tick();
      do_start(2'b11, 32'hFFFF_FFF9, 32'd2);
      wait_done(1, 33, "udiv_lat");
      check("udiv_hilo", {hi, lo}, 64'h0000_0001_7FFF_FFFC);
      tick();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Iterative multiply/divide unit with its own sequencer and the architectural HI/LO registers, backing the MUL, DIV and MFHI instructions.
- Accepts an operation from the decode stage and runs a WIDTH-cycle shift-add multiply or restoring divide.
- Holds the result in HI/LO.
- Raises a stall to the pipeline when HI/LO is read while an operation is still running.
- Sits beside the ALU in the execute stage.

Parameters:
WIDTH, 32, operand and HI/LO width; iteration count
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
start  in  1  request a new operation; accepted only when ready=1
op  in  2  bit0: 0=multiply, 1=divide; bit1: 1=signed (used only with SIGNED_MULDIV_EN)
a  in  WIDTH  multiplicand / dividend, sampled at accept
b  in  WIDTH  multiplier / divisor, sampled at accept
hilo_read  in  1  decode is executing MFHI/MFLO this cycle
ready  out  1  can accept start this cycle
busy  out  1  operation in progress
done  out  1  one-cycle pulse; hi/lo valid from this cycle
div_by_zero  out  1  sticky flag for last divide; cleared at next accept
stall  out  1  hilo_read & busy
hi  out  WIDTH  HI register (product upper half / remainder)
lo  out  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset values: state=IDLE, hi=0, lo=0, counter=0, done=0, busy=0, ready=1, div_by_zero=0, stall=0.
- States: IDLE, MUL_RUN, DIV_RUN, FIX (feature only), DONE.
- Accept: start & ready on clock edge.
  - Latch operands into working registers.
  - Load counter with WIDTH-1.
  - Go to MUL_RUN or DIV_RUN per op[0].
- MUL_RUN, one step per cycle:
  - If multiplier LSB=1, add multiplicand into the upper half of a 2*WIDTH accumulator, keeping the carry.
  - Shift accumulator and multiplier right by 1.
  - Product is mod 2^(2*WIDTH); no overflow flag.
- DIV_RUN, restoring divide, one quotient bit per cycle:
  - Shift {remainder, dividend} left by 1.
  - Trial-subtract divisor (WIDTH+1 bits); if the result is non-negative, keep it and set quotient bit 1.
- Counter decrements each RUN cycle. At counter=0 the next edge writes hi/lo and goes to DONE (or FIX for a signed op).
- Latency: accept at cycle 0 → done=1 at cycle WIDTH+1 (33 for WIDTH=32) unsigned; WIDTH+2 signed.
- DONE, single cycle: done=1, busy=0, ready=1. A start in DONE is accepted (back-to-back); otherwise go to IDLE.
- busy=1 in MUL_RUN, DIV_RUN, FIX. ready = (state==IDLE | state==DONE).
- start while busy: ignored, operands not sampled, no error.
- Divide by zero (b=0 at accept):
  - Skip DIV_RUN and go straight to DONE, so done is at cycle 1.
  - hi=a (unsigned), lo=all ones, div_by_zero=1.
- hi/lo hold their previous values throughout an operation and change only on the edge entering DONE.
- stall is combinational: hilo_read & busy. In DONE stall=0 and hi/lo are already updated.
- Reset mid-operation: abort; all state, hi and lo return to reset values on that edge.
- Simultaneous reset and start: reset wins, start is dropped.

Optional Feature:
SIGNED_MULDIV_EN
- Defined:
  - op[1]=1 selects signed operation.
  - At accept, operands are converted to magnitudes and the result signs are recorded.
  - After RUN, the FIX state (1 cycle) negates the results: product if sign(a)^sign(b); quotient if sign(a)^sign(b); remainder takes the sign of a.
  - Signed divide by zero: hi=a, lo=all ones, no FIX.
  - Most-negative / -1: lo=most-negative, hi=0, no trap.
- Undefined: op[1] is ignored, all operations are unsigned, FIX state and negation logic are absent.

Test Plan:
- Multiply: reset, then start op=00 a=7 b=6 at cycle 0 → busy cycles 1–32, done at cycle 33, lo=42, hi=0, div_by_zero=0.
- Multiply, full width: op=00 a=0xFFFFFFFF b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. A start pulsed during busy is ignored and the result is unchanged.
- Divide plus back-to-back: op=01 a=100 b=7 → lo=14, hi=2 at cycle 33. A start op=00 a=3 b=5 in the DONE cycle is accepted; then lo=15 at cycle 66.
- Divide by zero: op=01 a=5 b=0 → done at cycle 1, hi=5, lo=0xFFFFFFFF, div_by_zero=1. The next accept clears div_by_zero.
- Stall and reset: hilo_read=1 during busy → stall=1 and hi/lo keep old values. reset asserted at cycle 10 of a multiply → next cycle idle, ready=1, hi=lo=0, no done pulse.
- With SIGNED_MULDIV_EN, signed ops (done at cycle 34):
  - op=10 a=-7 b=6 → hi=0xFFFFFFFF, lo=0xFFFFFFD6.
  - op=11 a=-7 b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
